// File: rtl/de2_input_conditioner_if.sv
// Board-pin side and conditioned-output side of the DE2-115 input conditioner.
// master drives the raw pins and observes the outputs; slave is the conditioner.
`timescale 1ns/1ps
interface de2_input_conditioner_if #(
    parameter int unsigned NUM_KEYS = 4,
    parameter int unsigned NUM_SW   = 18
);
    logic [NUM_KEYS-1:0] key_n_in;
    logic [NUM_SW-1:0]   sw_in;
    logic [NUM_KEYS-1:0] key_out;
    logic [NUM_SW-1:0]   sw_out;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_SW-1:0]   sw_change;
    logic                tick_out;

    modport master (
        output key_n_in, sw_in,
        input  key_out, sw_out, key_press, key_release, sw_change, tick_out
    );

    modport slave (
        input  key_n_in, sw_in,
        output key_out, sw_out, key_press, key_release, sw_change, tick_out
    );
endinterface

// File: rtl/de2_input_conditioner.sv
// Synchronise, debounce and edge-detect the DE2-115 KEY/SW pins for the PIO exports.
// Define KEY_AUTOREPEAT_EN to add tick-based auto-repeat key_press pulses on held keys.
`timescale 1ns/1ps
module de2_input_conditioner #(
    parameter int unsigned NUM_KEYS           = 4,
    parameter int unsigned NUM_SW             = 18,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned TICK_CYCLES        = 50000,
    parameter int unsigned STABLE_TICKS       = 16,
    parameter int unsigned REPEAT_DELAY_TICKS = 500,
    parameter int unsigned REPEAT_RATE_TICKS  = 100
) (
    input  logic                   clk,
    input  logic                   reset_n,
    de2_input_conditioner_if.slave io
);

    localparam int unsigned NUM_BITS = NUM_KEYS + NUM_SW;
    localparam int unsigned PRE_W    = $clog2(TICK_CYCLES);
    localparam int unsigned CNT_W    = $clog2(STABLE_TICKS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    if (SYNC_STAGES < 2 || TICK_CYCLES < 2 || STABLE_TICKS < 2 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_param_check
        $error("de2_input_conditioner: parameter out of range");
    end

    // Key synchroniser holds raw pin polarity so reset loads 'released'.
    logic [NUM_KEYS-1:0] key_sync [SYNC_STAGES];
    logic [NUM_SW-1:0]   sw_sync  [SYNC_STAGES];
    logic [NUM_BITS-1:0] synced;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                key_sync[s] <= '1;
                sw_sync[s]  <= '0;
            end
        end else begin
            key_sync[0] <= io.key_n_in;
            sw_sync[0]  <= io.sw_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                key_sync[s] <= key_sync[s-1];
                sw_sync[s]  <= sw_sync[s-1];
            end
        end
    end

    assign synced = {sw_sync[SYNC_STAGES-1], ~key_sync[SYNC_STAGES-1]};

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    logic [NUM_BITS-1:0] stable;
    logic [NUM_BITS-1:0] mismatch;
    logic [NUM_BITS-1:0] qualify;
    logic [CNT_W-1:0]    db_cnt [NUM_BITS];

    always_comb begin
        mismatch = synced ^ stable;
        qualify  = '0;
        for (int unsigned b = 0; b < NUM_BITS; b++) begin
            qualify[b] = mismatch[b] && tick && (db_cnt[b] == CNT_LAST);
        end
    end

    // A qualifying bit always mismatches, so toggling stable adopts the synced level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= '0;
            for (int unsigned b = 0; b < NUM_BITS; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            stable <= stable ^ qualify;
            for (int unsigned b = 0; b < NUM_BITS; b++) begin
                if (!mismatch[b] || qualify[b]) begin
                    db_cnt[b] <= '0;
                end else if (tick) begin
                    db_cnt[b] <= db_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    logic [NUM_KEYS-1:0] rpt_fire;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                      REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_TICKS - 1);

    logic [RPT_W-1:0]    rpt_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rpt_started;

    // A qualifying key that is currently high is being released on this edge.
    always_comb begin
        rpt_fire = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            rpt_fire[k] = tick && stable[k] && !qualify[k] &&
                          (rpt_cnt[k] == (rpt_started[k] ? RPT_RATE_LAST : RPT_DELAY_LAST));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rpt_started <= '0;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                rpt_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (!stable[k]) begin
                    rpt_cnt[k]     <= '0;
                    rpt_started[k] <= 1'b0;
                end else if (rpt_fire[k]) begin
                    rpt_cnt[k]     <= '0;
                    rpt_started[k] <= 1'b1;
                end else if (tick) begin
                    rpt_cnt[k]     <= rpt_cnt[k] + RPT_W'(1);
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    logic [NUM_KEYS-1:0] key_press_q;
    logic [NUM_KEYS-1:0] key_release_q;
    logic [NUM_SW-1:0]   sw_change_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_press_q   <= '0;
            key_release_q <= '0;
            sw_change_q   <= '0;
        end else begin
            key_press_q   <= (qualify[NUM_KEYS-1:0] & synced[NUM_KEYS-1:0]) | rpt_fire;
            key_release_q <= qualify[NUM_KEYS-1:0] & ~synced[NUM_KEYS-1:0];
            sw_change_q   <= qualify[NUM_BITS-1:NUM_KEYS];
        end
    end

    assign io.key_out     = stable[NUM_KEYS-1:0];
    assign io.sw_out      = stable[NUM_BITS-1:NUM_KEYS];
    assign io.key_press   = key_press_q;
    assign io.key_release = key_release_q;
    assign io.sw_change   = sw_change_q;
    assign io.tick_out    = tick;

endmodule

// File: tb/tb_de2_input_conditioner.sv
// Self-checking bench for de2_input_conditioner: timestamp-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, random phase.
`timescale 1ns/1ps
module tb_de2_input_conditioner;

    localparam int NK = 4;
    localparam int NS = 18;
    localparam int NB = NK + NS;
    localparam int SY = 2;
    localparam int TC = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    de2_input_conditioner_if #(.NUM_KEYS(NK), .NUM_SW(NS)) io ();

    de2_input_conditioner #(
        .NUM_KEYS(NK), .NUM_SW(NS), .SYNC_STAGES(SY), .TICK_CYCLES(TC),
        .STABLE_TICKS(ST), .REPEAT_DELAY_TICKS(RD), .REPEAT_RATE_TICKS(RR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io(io)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int val, input int lo, input int hi);
        checks++;
        if (val < lo || val > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, val, lo, hi, $time);
        end
    endtask

    // Reference model: cycle index since reset release, timestamps of last agreement.
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_stable;
    int            last_ok [NB];
    int            cyc;
    logic [NK-1:0] e_press, e_release;
    logic [NS-1:0] e_change;
    logic          e_tick;
    bit            m_valid = 0;
`ifdef KEY_AUTOREPEAT_EN
    int            press_at [NK];
`endif

    function automatic int ticks_between(input int a, input int b);
        return (b + 1) / TC - (a + 1) / TC;
    endfunction

    function automatic bit is_tick(input int c);
        return (c % TC) == TC - 1;
    endfunction

    always @(posedge clk) begin
        logic [NB-1:0] s, up, dn;
        logic [NK-1:0] rpt;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < SY; i++) hist.push_back('0);
            m_stable  = '0;
            for (int b = 0; b < NB; b++) last_ok[b] = -1;
            cyc       = 0;
            e_press   = '0;
            e_release = '0;
            e_change  = '0;
            m_valid   = 1;
        end else begin
            s   = hist[SY-1];
            up  = '0;
            dn  = '0;
            rpt = '0;
            for (int b = 0; b < NB; b++) begin
                if (s[b] == m_stable[b]) begin
                    last_ok[b] = cyc;
                end else if (is_tick(cyc) && ticks_between(last_ok[b], cyc) == ST) begin
                    if (s[b]) up[b] = 1'b1;
                    else      dn[b] = 1'b1;
                    last_ok[b] = cyc;
                end
            end
`ifdef KEY_AUTOREPEAT_EN
            for (int k = 0; k < NK; k++) begin
                if (m_stable[k] && !dn[k] && is_tick(cyc)) begin
                    int n;
                    n = ticks_between(press_at[k], cyc);
                    if (n == RD || (n > RD && (n - RD) % RR == 0)) rpt[k] = 1'b1;
                end
                if (up[k]) press_at[k] = cyc;
            end
`endif
            m_stable  = (m_stable | up) & ~dn;
            e_press   = up[NK-1:0] | rpt;
            e_release = dn[NK-1:0];
            e_change  = up[NB-1:NK] | dn[NB-1:NK];
            hist.push_front({io.sw_in, ~io.key_n_in});
            void'(hist.pop_back());
            cyc++;
        end
        e_tick = is_tick(cyc);
    end

    // Per-cycle comparison plus event counters for the directed scenarios.
    int press_cnt [NK];
    int release_cnt [NK];
    int change_cnt [NS];
    int sw5_high;
    int change_events;
    logic [NS-1:0] change_val;
    int tcyc = 0;
    int press1_times [$];

    always @(posedge clk) tcyc++;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("key_out",     32'(io.key_out),     32'(m_stable[NK-1:0]));
            chk("sw_out",      32'(io.sw_out),      32'(m_stable[NB-1:NK]));
            chk("key_press",   32'(io.key_press),   32'(e_press));
            chk("key_release", 32'(io.key_release), 32'(e_release));
            chk("sw_change",   32'(io.sw_change),   32'(e_change));
            chk("tick_out",    32'(io.tick_out),    32'(e_tick));
        end
        for (int k = 0; k < NK; k++) begin
            if (io.key_press[k] === 1'b1)   press_cnt[k]++;
            if (io.key_release[k] === 1'b1) release_cnt[k]++;
        end
        for (int i = 0; i < NS; i++) if (io.sw_change[i] === 1'b1) change_cnt[i]++;
        if (io.sw_out[5] === 1'b1) sw5_high++;
        if (io.sw_change !== '0) begin
            change_events++;
            change_val = io.sw_change;
        end
        if (io.key_press[1] === 1'b1) press1_times.push_back(tcyc);
    end

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            press_cnt[k]   = 0;
            release_cnt[k] = 0;
        end
        for (int i = 0; i < NS; i++) change_cnt[i] = 0;
        sw5_high      = 0;
        change_events = 0;
        change_val    = '0;
        press1_times.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_key(input int k, input logic lvl, output int lat);
        lat = 0;
        while (lat < 20 && io.key_out[k] !== lvl) begin
            step(1);
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int others;
        clear_counts();

        // Reset with every input active, then power-on qualification.
        io.key_n_in = '0;
        io.sw_in    = '1;
        reset_n     = 1'b0;
        step(5);
        chk("rst_key_out", 32'(io.key_out), 32'h0);
        chk("rst_sw_out", 32'(io.sw_out), 32'h0);
        chk("rst_pulses", 32'({io.key_press, io.key_release, io.sw_change}), 32'h0);
        chk("rst_tick", 32'(io.tick_out), 32'h0);
        reset_n = 1'b1;
        step(3);  chk("tick_c3", 32'(io.tick_out), 32'h1);
        step(1);  chk("tick_c4", 32'(io.tick_out), 32'h0);
        step(3);  chk("tick_c7", 32'(io.tick_out), 32'h1);
        step(4);
        chk("pre_qual_key", 32'(io.key_out), 32'h0);
        chk("pre_qual_sw", 32'(io.sw_out), 32'h0);
        step(1);
        chk("qual_key", 32'(io.key_out), 32'hF);
        chk("qual_sw", 32'(io.sw_out), 32'h3FFFF);
        chk("qual_press", 32'(io.key_press), 32'hF);
        chk("qual_change", 32'(io.sw_change), 32'h3FFFF);
        step(1);
        chk("qual_press_end", 32'(io.key_press), 32'h0);
        chk("qual_change_end", 32'(io.sw_change), 32'h0);

        io.key_n_in = '1;
        io.sw_in    = '0;
        step(20);
        chk("idle_key", 32'(io.key_out), 32'h0);
        chk("idle_sw", 32'(io.sw_out), 32'h0);

        // Clean press and release of key 0.
        clear_counts();
        io.key_n_in[0] = 1'b0;
        wait_key(0, 1'b1, lat);
        chk_range("press_latency", lat, 11, 14);
        step(40 - lat);
        io.key_n_in[0] = 1'b1;
        wait_key(0, 1'b0, lat);
        chk_range("release_latency", lat, 11, 14);
        step(6);
        chk("press_count0", 32'(press_cnt[0]), 32'd1);
        chk("release_count0", 32'(release_cnt[0]), 32'd1);
        others = 0;
        for (int k = 1; k < NK; k++) others += press_cnt[k] + release_cnt[k];
        for (int i = 0; i < NS; i++) others += change_cnt[i];
        chk("quiet_others", 32'(others), 32'd0);

        // Bounce on switch 5 never qualifies.
        clear_counts();
        io.sw_in[5] = 1'b1; step(5);
        io.sw_in[5] = 1'b0; step(3);
        io.sw_in[5] = 1'b1; step(5);
        io.sw_in[5] = 1'b0; step(30);
        chk("bounce_sw5_high", 32'(sw5_high), 32'd0);
        chk("bounce_sw5_change", 32'(change_cnt[5]), 32'd0);

        // Two switches change together and pulse together.
        clear_counts();
        io.sw_in[0]  = 1'b1;
        io.sw_in[17] = 1'b1;
        step(20);
        chk("simul_events", 32'(change_events), 32'd1);
        chk("simul_change", 32'(change_val), 32'h20001);
        chk("simul_sw_out", 32'(io.sw_out), 32'h20001);

        // Reset in the middle of a key debounce restarts qualification.
        io.key_n_in[2] = 1'b0;
        step(7);
        chk("mid_key2_before", 32'(io.key_out[2]), 32'h0);
        reset_n = 1'b0;
        step(1);
        chk("mid_rst_key", 32'(io.key_out), 32'h0);
        chk("mid_rst_sw", 32'(io.sw_out), 32'h0);
        reset_n = 1'b1;
        wait_key(2, 1'b1, lat);
        chk_range("mid_requal_latency", lat, 11, 14);

        io.key_n_in = '1;
        io.sw_in    = '0;
        step(20);

`ifdef KEY_AUTOREPEAT_EN
        clear_counts();
        io.key_n_in[1] = 1'b0;
        step(80);
        io.key_n_in[1] = 1'b1;
        wait_key(1, 1'b0, lat);
        others = tcyc;
        step(20);
        chk("rpt_count_min", 32'(press1_times.size() >= 3), 32'h1);
        if (press1_times.size() >= 3) begin
            chk("rpt_first_gap", 32'(press1_times[1] - press1_times[0]), 32'd20);
            chk("rpt_rate_gap", 32'(press1_times[2] - press1_times[1]), 32'd8);
            chk("rpt_after_release", 32'(press1_times[press1_times.size()-1] < others), 32'h1);
        end
        chk("rpt_release_count", 32'(release_cnt[1]), 32'd1);
`endif

        // Random phase: sparse toggles biased towards a few bits, rare resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                int b;
                b = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5))
                                                : int'($urandom_range(0, NB - 1));
                if (b < NK) io.key_n_in[b] = ~io.key_n_in[b];
                else        io.sw_in[b - NK] = ~io.sw_in[b - NK];
            end
            reset_n = ($urandom_range(0, 499) != 0);
            step(1);
        end
        reset_n = 1'b1;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/de2_input_conditioner.md
Name: de2_input_conditioner

Overview:
- Conditions the raw DE2-115 pushbuttons (KEY, active-low, bouncing) and slider switches (SW) before they reach the Computer_System pushbuttons and slider_switches PIO inputs.
- Synchronises each input, debounces it against a shared millisecond-scale tick, and presents clean active-high levels plus one-cycle press/release/change pulses.
- Sits between the board pins and the system's PIO exports, in the system clock domain.

Parameters:
- NUM_KEYS, 4, number of pushbuttons.
- NUM_SW, 18, number of slider switches.
- SYNC_STAGES, 2, synchroniser flops per input (min 2).
- TICK_CYCLES, 50000, clk cycles per debounce tick (1 ms at 50 MHz).
- STABLE_TICKS, 16, consecutive ticks of mismatch required to accept a new level (min 2).
- REPEAT_DELAY_TICKS, 500, ticks from press to first auto-repeat pulse (optional feature only).
- REPEAT_RATE_TICKS, 100, ticks between later auto-repeat pulses (optional feature only).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- key_n_in  in  NUM_KEYS  raw KEY pins; 0 = pressed
- sw_in  in  NUM_SW  raw SW pins
- key_out  out  NUM_KEYS  debounced; 1 = pressed; drives pushbuttons_export
- sw_out  out  NUM_SW  debounced switch levels; drives slider_switches_export
- key_press  out  NUM_KEYS  one-cycle pulse when key_out bit rises (and on auto-repeat)
- key_release  out  NUM_KEYS  one-cycle pulse when key_out bit falls
- sw_change  out  NUM_SW  one-cycle pulse when sw_out bit toggles
- tick_out  out  1  debounce tick strobe, for bench observation

Behaviour:
- One clock. Reset is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (reset_n=0 at an edge):
  - key_out, sw_out, key_press, key_release, sw_change, tick_out = 0.
  - Prescaler and all per-bit counters = 0.
  - Key synchroniser flops load 1 (released); switch synchroniser flops load 0.
- Reset mid-operation aborts any debounce in progress. Outputs restart from 0; a switch held high re-qualifies after a full debounce.
- Inputs are inverted for keys (pressed = 1) and passed through SYNC_STAGES flops. "synced" below means the last stage.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick_out=1 for exactly the one cycle in which the count equals TICK_CYCLES-1.
  - The first tick occurs TICK_CYCLES cycles after reset release.
- Per-bit debouncer (identical for keys and switches), with stable = the current output bit:
  - synced == stable on any cycle: counter clears to 0, regardless of tick.
  - synced != stable and tick: if counter == STABLE_TICKS-1, then stable <= synced and counter <= 0; otherwise counter increments.
  - synced != stable and no tick: counter holds.
  - Counter width is clog2(STABLE_TICKS). It never exceeds STABLE_TICKS-1, so it cannot wrap.
- Latency: an output flips on the edge of the STABLE_TICKS-th consecutive mismatching tick. That is between (STABLE_TICKS-1)*TICK_CYCLES+1 and STABLE_TICKS*TICK_CYCLES cycles after synced changes, plus SYNC_STAGES cycles of pin-to-synced delay.
- Glitches: any mismatch lasting fewer than STABLE_TICKS ticks produces no output change and no pulse.
- Pulses are registered and asserted in the cycle immediately after the output bit changes, for exactly one cycle:
  - key_press on a 0->1 change of key_out.
  - key_release on a 1->0 change of key_out.
  - sw_change on either change of sw_out.
- Bits are fully independent. Simultaneous changes on several bits each qualify and pulse independently, possibly in the same cycle.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each key has a repeat counter, counting ticks while key_out=1 and cleared while key_out=0.
  - An extra key_press pulse is issued REPEAT_DELAY_TICKS ticks after the rising pulse, then every REPEAT_RATE_TICKS ticks while the key stays held.
  - Repeat pulses use the same one-cycle timing, aligned to the cycle after the qualifying tick.
  - Release stops repeats immediately; no repeat pulse is issued in the cycle of, or after, the release.
- Undefined: key_press pulses only on the debounced rising edge; the REPEAT_* parameters are ignored.

Test Plan:
Bench parameters: TICK_CYCLES=4, STABLE_TICKS=3, SYNC_STAGES=2.
- Reset behaviour: hold reset_n=0 for 5 cycles with key_n_in=4'b0000, sw_in=18'h3FFFF -> all outputs 0 during reset. After release: tick_out pulses every 4 cycles; key_out=4'hF and sw_out=18'h3FFFF within 2+12 cycles; key_press=4'hF and sw_change=18'h3FFFF each pulse for exactly 1 cycle.
- Clean press/release: drive key_n_in[0]=0 for 40 cycles, then 1 -> key_out[0] rises 11..14 cycles after the pin change with a single key_press[0] pulse; it falls 11..14 cycles after the release edge with a single key_release[0] pulse; other bits stay quiet.
- Bounce rejection: toggle sw_in[5] high 5 cycles, low 3, high 5, low permanently -> sw_out[5] stays 0 and sw_change[5] never asserts.
- Simultaneous events: change sw_in[0] and sw_in[17] in the same cycle, and hold for 20 cycles -> both sw_out bits flip on the same edge and sw_change=18'h20001 for one cycle.
- Reset mid-debounce: start key_n_in[2]=0, then pulse reset_n=0 for 1 cycle after 7 cycles -> key_out[2] stays 0 through the reset, then qualifies a full 11..14 cycles after reset release.
- KEY_AUTOREPEAT_EN (REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2): hold key 1 for 80 cycles -> initial key_press[1], then repeats 20 cycles later and every 8 cycles after that; no pulses after key_release[1].
